// File: rtl/ipc_link_host.sv
// ipc_link_host: ZX8302-side bit-serial exchange with the 8049 IPC; optional per-bit watchdog via IPC_TIMEOUT_EN.
// Latency: start -> first comdata_out bit 1 clk; synchronized last strobe rise -> done 1 clk.
// Backpressure: paced entirely by the IPC strobe; start is ignored while busy and in the done clk.
module ipc_link_host #(
  parameter int SETUP_TICKS   = 4,
  parameter int TIMEOUT_TICKS = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_11m,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic [3:0] nbits,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       timeout,
  input  logic       comctrl,
  input  logic       comdata_in,
  output logic       comdata_out
);
  localparam int SW = $clog2(SETUP_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT_LO, S_WAIT_HI, S_DONE} state_t;
  state_t state, state_nx;

  logic [1:0]    ctrl_sync, din_sync;
  logic          ctrl_prev, ctrl_fall, ctrl_rise;
  logic [7:0]    tx_ld;
  logic [6:0]    tx_sh;
  logic [3:0]    bit_cnt, n_eff;
  logic [SW-1:0] setup_cnt;
  logic          load, sample, abort, expire, setup_end, last_bit;

  // Both IPC lines are asynchronous; the extra ctrl_prev flop gives clean edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_sync <= 2'b11;
      din_sync  <= 2'b11;
      ctrl_prev <= 1'b1;
    end else begin
      ctrl_sync <= {ctrl_sync[0], comctrl};
      din_sync  <= {din_sync[0], comdata_in};
      ctrl_prev <= ctrl_sync[1];
    end
  end

  assign ctrl_fall = ctrl_prev & ~ctrl_sync[1];
  assign ctrl_rise = ~ctrl_prev & ctrl_sync[1];
  assign n_eff     = (nbits == 4'd0 || nbits > 4'd8) ? 4'd8 : nbits;
  // Left-justify the word so the bit on the wire is always the MSB of the shifter.
  assign tx_ld     = tx_data << (4'd8 - n_eff);
  assign setup_end = ce_11m && (setup_cnt == SW'(SETUP_TICKS - 1));
  assign last_bit  = (bit_cnt == 4'd1);
  assign busy      = (state == S_SETUP) || (state == S_WAIT_LO) || (state == S_WAIT_HI);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    sample   = 1'b0;
    abort    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        load     = 1'b1;
        state_nx = S_SETUP;
      end
      S_SETUP: if (setup_end) state_nx = S_WAIT_LO;
      S_WAIT_LO: begin
        if (ctrl_fall) state_nx = S_WAIT_HI;
        else if (expire) begin
          abort    = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_WAIT_HI: begin
        if (ctrl_rise) begin
          sample   = 1'b1;
          state_nx = last_bit ? S_DONE : S_SETUP;
        end else if (expire) begin
          abort    = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sh       <= '0;
      bit_cnt     <= '0;
      setup_cnt   <= '0;
      rx_data     <= '0;
      comdata_out <= 1'b1;
    end else begin
      if (state != S_SETUP) setup_cnt <= '0;
      else if (ce_11m)      setup_cnt <= setup_cnt + 1'b1;

      if (load) begin
        tx_sh       <= tx_ld[6:0];
        bit_cnt     <= n_eff;
        rx_data     <= '0;
        comdata_out <= tx_ld[7];
      end else if (sample) begin
        rx_data     <= {rx_data[6:0], din_sync[1]};
        bit_cnt     <= bit_cnt - 1'b1;
        tx_sh       <= {tx_sh[5:0], 1'b0};
        comdata_out <= last_bit ? 1'b1 : tx_sh[6];
      end else if (abort) begin
        comdata_out <= 1'b1;
      end
    end
  end

`ifdef IPC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] to_cnt;
  logic          waiting;

  assign waiting = (state == S_WAIT_LO) || (state == S_WAIT_HI);
  assign expire  = waiting && ce_11m && (to_cnt == TW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == S_SETUP)         to_cnt <= '0;
      else if (waiting && ce_11m)   to_cnt <= to_cnt + 1'b1;
      if (load)       timeout <= 1'b0;
      else if (abort) timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_ticks;
  assign unused_timeout_ticks = |TIMEOUT_TICKS;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ipc_link_host.sv
// Bench for ipc_link_host: randomized transfers against an IPC strobe model; a done-driven
// monitor pops expected {timeout, rx_data} from a scoreboard queue filled at stimulus time.
module tb_ipc_link_host;
  logic       clk = 1'b0, reset_n = 1'b0, ce_11m = 1'b0, start = 1'b0;
  logic       comctrl = 1'b1, comdata_in = 1'b1;
  logic [7:0] tx_data = '0;
  logic [3:0] nbits = '0;
  logic       busy, done, timeout, comdata_out;
  logic [7:0] rx_data;

  int         checks = 0, failures = 0, done_cnt = 0;
  logic       done_prev = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] last_rx = 8'h00;
  logic       have_last = 1'b0;

  ipc_link_host #(.SETUP_TICKS(4), .TIMEOUT_TICKS(100)) dut (
    .clk(clk), .reset_n(reset_n), .ce_11m(ce_11m), .start(start),
    .tx_data(tx_data), .nbits(nbits), .busy(busy), .done(done),
    .rx_data(rx_data), .timeout(timeout), .comctrl(comctrl),
    .comdata_in(comdata_in), .comdata_out(comdata_out)
  );

  always #5 clk = ~clk;

  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      c++;
      ce_11m = (c % 4 == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset_n && done) begin
      done_cnt++;
      check("done_width", done_prev, 0);
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_rx_data", rx_data, e[7:0]);
        check("sb_timeout", timeout, e[8]);
        check("done_line_released", comdata_out, 1);
        check("done_not_busy", busy, 0);
      end
    end
    done_prev = reset_n && done;
  end

  // IPC model. mode: 0 normal, 1 start mid-transfer, 2 strobe held low + glitch in setup,
  // 3 reset after 3 bits, 4 start during the done clk.
  task automatic xfer(input logic [7:0] tx, input logic [3:0] nb, input logic [7:0] rw, input int mode);
    int n, d0, k;
    logic [7:0] mask, exp_rx;
    n      = (nb == 4'd0 || nb > 4'd8) ? 8 : int'(nb);
    mask   = 8'((9'd1 << n) - 9'd1);
    exp_rx = rw & mask;
    @(negedge clk);
    if (have_last) check("rx_hold", rx_data, last_rx);
    tx_data = tx;
    nbits   = nb;
    if (mode == 2) comctrl = 1'b0;
    if (mode != 3) exp_q.push_back({1'b0, exp_rx});
    d0    = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("first_bit", comdata_out, tx[n-1]);
    check("timeout_clr", timeout, 0);
    if (mode == 2) begin
      repeat (30) @(negedge clk);
      comctrl = 1'b1;
      repeat (6) @(negedge clk);
    end
    for (int i = n - 1; i >= 0; i--) begin
      comdata_in = rw[i];
      repeat (30 + $urandom_range(0, 6)) @(negedge clk);
      check("bit_setup", comdata_out, tx[i]);
      if (i == 0) check("no_early_done", done_cnt, d0);
      comctrl = 1'b0;
      repeat ($urandom_range(4, 8)) @(negedge clk);
      check("bit_hold", comdata_out, tx[i]);
      comctrl = 1'b1;
      if (i > 0) repeat (6) @(negedge clk);
      if (mode == 3 && i == n - 3) begin
        reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rx", rx_data, 0);
        check("rst_line", comdata_out, 1);
        check("rst_done", done, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("no_done_after_reset", done_cnt, d0);
        last_rx   = 8'h00;
        have_last = 1'b1;
        return;
      end
      if (mode == 1 && i == n - 2) begin
        tx_data = ~tx;
        nbits   = 4'd1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        tx_data = tx;
        nbits   = nb;
        check("start_ignored_busy", busy, 1);
        check("start_ignored_bit", comdata_out, tx[i-1]);
      end
      if (mode == 2 && i > 0 && i == n - 1) begin
        comctrl = 1'b0;
        repeat (3) @(negedge clk);
        comctrl = 1'b1;
      end
    end
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    if (!done) exp_q.delete();
    if (mode == 4 && done) begin
      tx_data = ~tx;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      tx_data = tx;
      check("start_in_done_ignored", busy, 0);
    end else begin
      @(negedge clk);
    end
    check("idle_busy", busy, 0);
    check("idle_line", comdata_out, 1);
    last_rx   = exp_rx;
    have_last = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rx", rx_data, 0);
    check("reset_timeout", timeout, 0);
    check("reset_line", comdata_out, 1);
    reset_n = 1'b1;
    have_last = 1'b1;
    @(negedge clk);

    xfer(8'hA5, 4'd8, 8'h3C, 0);
    xfer(8'h0B, 4'd4, 8'h09, 0);
    xfer(8'($urandom), 4'd0, 8'($urandom), 1);
    xfer(8'($urandom), 4'd8, 8'($urandom), 4);
    xfer(8'($urandom), 4'd6, 8'($urandom), 2);
    xfer(8'($urandom), 4'd8, 8'($urandom), 3);
    xfer(8'hC3, 4'd8, 8'h96, 0);
    for (int t = 0; t < 6; t++)
      xfer(8'($urandom), 4'($urandom_range(0, 15)), 8'($urandom), 0);

`ifdef IPC_TIMEOUT_EN
    begin
      int d0, k;
      @(negedge clk);
      check("rx_hold_pre_to", rx_data, last_rx);
      tx_data = 8'h5A;
      nbits   = 4'd0;
      exp_q.push_back({1'b1, 8'h00});
      d0    = done_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      check("to_not_early", done_cnt, d0);
      k = 0;
      while (!done && k < 400) begin
        @(negedge clk);
        k++;
      end
      check("to_done", done, 1);
      check("to_flag", timeout, 1);
      check("to_line", comdata_out, 1);
      if (!done) exp_q.delete();
      @(negedge clk);
      check("to_sticky", timeout, 1);
      last_rx   = 8'h00;
      have_last = 1'b1;
      xfer(8'($urandom), 4'd3, 8'($urandom), 0);
    end
`endif

    repeat (10) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
